// File: rtl/arb_mux.sv
// arb_mux: N-channel registered multiplexer with valid/ready handshake.
// One requesting channel is granted per transfer, chosen by MODE:
//   0 = external select (sel), 1 = fixed priority (ch0 highest), 2 = round-robin.
// The output slot reloads in the same cycle it drains, so a consumer that
// keeps out_ready high receives one word per cycle.
module arb_mux #(
    parameter int WIDTH = 8,
    parameter int N     = 4,
    parameter int MODE  = 2,
    localparam int SELW = $clog2(N)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N-1:0]         in_valid,
    input  logic [N*WIDTH-1:0]   in_data,
    output logic [N-1:0]         in_ready,
    input  logic [SELW-1:0]      sel,
    output logic                 out_valid,
    output logic [WIDTH-1:0]     out_data,
    output logic [SELW-1:0]      out_ch,
    input  logic                 out_ready
);

    logic            load_en;
    logic            grant_found;
    logic [SELW-1:0] grant_idx;
    logic [SELW-1:0] rr_ptr;

    // The slot may take a new word when it is empty or being drained this cycle.
    assign load_en = ~out_valid | out_ready;

    // Grant selection: produces the single granted channel index, if any.
    always_comb begin
        int              cand;
        logic [SELW-1:0] cand_idx;
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = 0;
        cand_idx    = '0;
        case (MODE)
            0: begin
                if (int'(sel) < N) begin
                    if (in_valid[sel]) begin
                        grant_found = 1'b1;
                        grant_idx   = sel;
                    end
                end
            end
            1: begin
                // Descending scan so the lowest valid index is the one left standing.
                for (int i = N - 1; i >= 0; i--) begin
                    if (in_valid[i]) begin
                        grant_found = 1'b1;
                        grant_idx   = SELW'(i);
                    end
                end
            end
            default: begin
                // Search starts just after the last served channel and wraps modulo N.
                for (int k = 1; k <= N; k++) begin
                    cand     = (int'(rr_ptr) + k) % N;
                    cand_idx = SELW'(cand);
                    if (!grant_found && in_valid[cand_idx]) begin
                        grant_found = 1'b1;
                        grant_idx   = cand_idx;
                    end
                end
            end
        endcase
    end

    // Handshake back to the producers: one-hot or zero, suppressed during reset.
    always_comb begin
        in_ready = '0;
        if (rst_n && load_en && grant_found) begin
            in_ready[grant_idx] = 1'b1;
        end
    end

    // Output slot and round-robin pointer; the pointer only moves on a transfer.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_ch    <= '0;
            rr_ptr    <= SELW'(N - 1);
        end else if (load_en) begin
            if (grant_found) begin
                out_valid <= 1'b1;
                out_data  <= in_data[int'(grant_idx)*WIDTH +: WIDTH];
                out_ch    <= grant_idx;
                if (MODE == 2) begin
                    rr_ptr <= grant_idx;
                end
            end else begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_arb_mux.sv
// Bench for arb_mux: round-robin build driven from a vector table with a
// scoreboard of words in flight, plus short sequences for the fixed-priority
// and external-select builds.
module tb_arb_mux;

    logic clk;
    logic rst_n;

    // Round-robin instance (N=4)
    logic [3:0]  rr_valid;
    logic [31:0] rr_data;
    logic [3:0]  rr_ready;
    logic [1:0]  rr_sel;
    logic        rr_ovalid;
    logic [7:0]  rr_odata;
    logic [1:0]  rr_och;
    logic        rr_oready;

    // Fixed-priority instance (N=4)
    logic [3:0]  pr_valid;
    logic [31:0] pr_data;
    logic [3:0]  pr_ready;
    logic [1:0]  pr_sel;
    logic        pr_ovalid;
    logic [7:0]  pr_odata;
    logic [1:0]  pr_och;
    logic        pr_oready;

    // External-select instance (N=8)
    logic [7:0]  es_valid;
    logic [63:0] es_data;
    logic [7:0]  es_ready;
    logic [2:0]  es_sel;
    logic        es_ovalid;
    logic [7:0]  es_odata;
    logic [2:0]  es_och;
    logic        es_oready;

    arb_mux #(.WIDTH(8), .N(4), .MODE(2)) u_rr (
        .clk(clk), .rst_n(rst_n), .in_valid(rr_valid), .in_data(rr_data),
        .in_ready(rr_ready), .sel(rr_sel), .out_valid(rr_ovalid),
        .out_data(rr_odata), .out_ch(rr_och), .out_ready(rr_oready)
    );

    arb_mux #(.WIDTH(8), .N(4), .MODE(1)) u_pr (
        .clk(clk), .rst_n(rst_n), .in_valid(pr_valid), .in_data(pr_data),
        .in_ready(pr_ready), .sel(pr_sel), .out_valid(pr_ovalid),
        .out_data(pr_odata), .out_ch(pr_och), .out_ready(pr_oready)
    );

    arb_mux #(.WIDTH(8), .N(8), .MODE(0)) u_es (
        .clk(clk), .rst_n(rst_n), .in_valid(es_valid), .in_data(es_data),
        .in_ready(es_ready), .sel(es_sel), .out_valid(es_ovalid),
        .out_data(es_odata), .out_ch(es_och), .out_ready(es_oready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] v;
        logic       rdy;
        logic       rst;
        logic [3:0] ir;
    } vec_t;

    typedef struct {
        logic [1:0] ch;
        logic [7:0] d;
    } exp_t;

    vec_t tbl[$];
    exp_t sb[$];
    int   n_cmp;
    int   n_bad;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic add(input logic [3:0] v, input logic rdy, input logic rst, input logic [3:0] ir);
        vec_t r;
        r.v   = v;
        r.rdy = rdy;
        r.rst = rst;
        r.ir  = ir;
        tbl.push_back(r);
    endtask

    initial begin
        logic armed;
        logic prev_rst;
        exp_t e;
        n_cmp = 0;
        n_bad = 0;
        armed = 1'b0;
        prev_rst = 1'b0;

        rst_n = 1'b0;
        rr_valid = '0; rr_data = '0; rr_sel = '0; rr_oready = 1'b0;
        pr_valid = '0; pr_data = '0; pr_sel = '0; pr_oready = 1'b0;
        es_valid = '0; es_data = '0; es_sel = '0; es_oready = 1'b0;

        // valid, out_ready, rst_n, expected in_ready
        add(4'b1111, 1'b1, 1'b0, 4'b0000);
        add(4'b1111, 1'b1, 1'b1, 4'b0001);   // wrap from reset pointer N-1
        add(4'b1111, 1'b1, 1'b1, 4'b0010);
        add(4'b1111, 1'b1, 1'b1, 4'b0100);
        add(4'b1111, 1'b1, 1'b1, 4'b1000);
        add(4'b1111, 1'b1, 1'b1, 4'b0001);
        for (int i = 0; i < 5; i++) add(4'b1111, 1'b0, 1'b1, 4'b0000); // stall
        add(4'b1111, 1'b1, 1'b1, 4'b0010);   // follows last served ch0
        for (int i = 0; i < 3; i++) add(4'b1000, 1'b1, 1'b1, 4'b1000);
        add(4'b1111, 1'b1, 1'b1, 4'b0001);   // wrap after ch3
        add(4'b0000, 1'b1, 1'b1, 4'b0000);
        add(4'b0000, 1'b1, 1'b1, 4'b0000);
        add(4'b0110, 1'b0, 1'b1, 4'b0010);   // empty slot loads regardless of out_ready
        add(4'b0110, 1'b0, 1'b1, 4'b0000);
        add(4'b0110, 1'b1, 1'b1, 4'b0100);
        add(4'b0011, 1'b1, 1'b1, 4'b0001);
        add(4'b0011, 1'b0, 1'b1, 4'b0000);
        add(4'b1111, 1'b0, 1'b0, 4'b0000);   // reset with a pending word
        add(4'b1111, 1'b1, 1'b1, 4'b0001);
        add(4'b1111, 1'b1, 1'b1, 4'b0010);
        add(4'b0000, 1'b1, 1'b1, 4'b0000);

        foreach (tbl[k]) begin
            @(negedge clk);
            rst_n     = tbl[k].rst;
            rr_valid  = tbl[k].v;
            rr_oready = tbl[k].rdy;
            for (int i = 0; i < 4; i++) rr_data[i*8 +: 8] = 8'(k*8 + i + 1);
            #1;
            chk($sformatf("rr_in_ready[%0d]", k), 32'(rr_ready), 32'(tbl[k].ir));
            if (armed) begin
                chk($sformatf("rr_out_valid[%0d]", k), 32'(rr_ovalid), 32'(sb.size() != 0));
                if (sb.size() != 0) begin
                    chk($sformatf("rr_out_ch[%0d]", k), 32'(rr_och), 32'(sb[0].ch));
                    chk($sformatf("rr_out_data[%0d]", k), 32'(rr_odata), 32'(sb[0].d));
                end
                if (prev_rst) begin
                    chk($sformatf("rr_rst_data[%0d]", k), 32'(rr_odata), 32'h0);
                    chk($sformatf("rr_rst_ch[%0d]", k), 32'(rr_och), 32'h0);
                end
            end
            if (!tbl[k].rst) begin
                sb.delete();
                armed = 1'b1;
            end else begin
                if (sb.size() != 0 && tbl[k].rdy) void'(sb.pop_front());
                for (int i = 0; i < 4; i++) begin
                    if (tbl[k].ir[i]) begin
                        e.ch = 2'(i);
                        e.d  = 8'(k*8 + i + 1);
                        sb.push_back(e);
                    end
                end
            end
            prev_rst = !tbl[k].rst;
        end
        chk("rr_sb_empty", 32'(sb.size()), 32'h0);

        // Fixed priority: ch1 always wins over ch3, ch0 wins over all.
        pr_data = {8'hC3, 8'h77, 8'h5A, 8'h11};
        pr_oready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            pr_valid = 4'b1010;
            #1;
            chk("pr_in_ready", 32'(pr_ready), 32'h2);
            chk("pr_out_valid", 32'(pr_ovalid), 32'(c != 0));
            if (c != 0) begin
                chk("pr_out_ch", 32'(pr_och), 32'h1);
                chk("pr_out_data", 32'(pr_odata), 32'h5A);
            end
        end
        @(negedge clk);
        pr_valid = 4'b1111;
        #1;
        chk("pr_all_in_ready", 32'(pr_ready), 32'h1);
        @(negedge clk);
        pr_valid = 4'b0000;
        #1;
        chk("pr_idle_in_ready", 32'(pr_ready), 32'h0);
        chk("pr_ch0_out_ch", 32'(pr_och), 32'h0);
        chk("pr_ch0_out_data", 32'(pr_odata), 32'h11);

        // External select on an N=8 build with only the low four channels driven.
        es_oready = 1'b1;
        es_data   = 64'h0;
        es_data[2*8 +: 8] = 8'hA5;
        es_data[3*8 +: 8] = 8'h3C;
        @(negedge clk);
        es_sel = 3'd2;
        es_valid = 8'b0000_0100;
        #1;
        chk("es_sel2_in_ready", 32'(es_ready), 32'h04);
        chk("es_pre_out_valid", 32'(es_ovalid), 32'h0);
        @(negedge clk);
        es_valid = 8'b0000_0000;
        #1;
        chk("es_sel2_out_valid", 32'(es_ovalid), 32'h1);
        chk("es_sel2_out_data", 32'(es_odata), 32'hA5);
        chk("es_sel2_out_ch", 32'(es_och), 32'h2);
        chk("es_idle_in_ready", 32'(es_ready), 32'h0);
        @(negedge clk);
        es_sel = 3'd5;
        es_valid = 8'b0000_1111;
        #1;
        chk("es_sel5_in_ready", 32'(es_ready), 32'h0);
        @(negedge clk);
        #1;
        chk("es_sel5_out_valid", 32'(es_ovalid), 32'h0);
        chk("es_sel5_hold_data", 32'(es_odata), 32'hA5);
        chk("es_sel5_hold_ch", 32'(es_och), 32'h2);
        es_sel = 3'd1;
        es_valid = 8'b0000_1101;
        #1;
        chk("es_sel1_invalid", 32'(es_ready), 32'h0);
        @(negedge clk);
        es_sel = 3'd3;
        #1;
        chk("es_sel3_in_ready", 32'(es_ready), 32'h08);
        @(negedge clk);
        es_valid = 8'b0000_0000;
        #1;
        chk("es_sel3_out_ch", 32'(es_och), 32'h3);
        chk("es_sel3_out_data", 32'(es_odata), 32'h3C);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
